// File: rtl/mux_sel_scanner_pkg.sv
// mux_sel_scanner_pkg: shared widths and FSM state encoding for the channel scanner.
package mux_sel_scanner_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_OUT} state_t;
endpackage

// File: rtl/mux_sel_scanner_if.sv
// mux_sel_scanner_if: mux select/return path plus the valid/ready sample output.
interface mux_sel_scanner_if;
    import mux_sel_scanner_pkg::*;
    logic i_en;
    logic [NUM_CH-1:0] i_ch_en;
    logic [DATA_W-1:0] i_mux_y;
    logic [SEL_W-1:0] o_sel;
    logic [DATA_W-1:0] o_data;
    logic [SEL_W-1:0] o_ch;
    logic o_valid;
    logic i_ready;
    logic o_busy;
    modport master (
        input i_en, i_ch_en, i_mux_y, i_ready,
        output o_sel, o_data, o_ch, o_valid, o_busy
    );
    modport slave (
        output i_en, i_ch_en, i_mux_y, i_ready,
        input o_sel, o_data, o_ch, o_valid, o_busy
    );
endinterface

// File: rtl/mux_sel_scanner_rr_next4.sv
// rr_next4: first enabled channel after sel (wrapping); incl makes sel itself the first candidate.
module rr_next4
    import mux_sel_scanner_pkg::*;
(
    input logic [SEL_W-1:0] sel,
    input logic [NUM_CH-1:0] mask,
    input logic incl,
    output logic [SEL_W-1:0] nxt
);
    logic [SEL_W-1:0] idx;
    // Walk candidates farthest-first so the nearest enabled one wins the last assignment.
    always_comb begin
        nxt = sel;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = sel + SEL_W'(k) + SEL_W'(!incl);
            nxt = mask[idx] ? idx : nxt;
        end
    end
endmodule

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin 4:1 mux select driver that dwells, samples the muxed byte
// and presents it with its channel on a valid/ready output.
module mux_sel_scanner
    import mux_sel_scanner_pkg::*;
#(
    parameter int DWELL = 4
) (
    input logic i_clk,
    input logic i_rst,
    mux_sel_scanner_if.master bus
);
    localparam int CNT_W = $clog2(DWELL + 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_start, sel_adv;
    logic any_en, go, done, hs;
    assign any_en = |bus.i_ch_en;
    assign go = bus.i_en && any_en;
    assign done = cnt == CNT_W'(DWELL - 1);
    assign hs = bus.o_valid && bus.i_ready;
    rr_next4 u_start (.sel(bus.o_sel), .mask(bus.i_ch_en), .incl(1'b1), .nxt(sel_start));
    rr_next4 u_adv (.sel(bus.o_sel), .mask(bus.i_ch_en), .incl(1'b0), .nxt(sel_adv));
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = go ? ST_DWELL : ST_IDLE;
            ST_DWELL: state_nx = !bus.i_en ? ST_IDLE : done ? ST_OUT : ST_DWELL;
            ST_OUT: state_nx = !hs ? ST_OUT : go ? ST_DWELL : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_comb bus.o_busy = state == ST_DWELL || state == ST_OUT;
    // An abort (i_en low) takes precedence over sampling on the final dwell cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
            bus.o_sel <= '0;
            bus.o_data <= '0;
            bus.o_ch <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        bus.o_sel <= sel_start;
                        cnt <= '0;
                    end
                end
                ST_DWELL: begin
                    cnt <= cnt + 1'b1;
                    if (bus.i_en && done) begin
                        bus.o_data <= bus.i_mux_y;
                        bus.o_ch <= bus.o_sel;
                        bus.o_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (hs) begin
                        bus.o_valid <= 1'b0;
                        cnt <= '0;
                        if (any_en) bus.o_sel <= sel_adv;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb_mux_sel_scanner: directed checks of scan order, dwell timing, masking, backpressure,
// abort and reset, with an A0+channel mux model on the select path.
module tb_mux_sel_scanner;
    logic clk = 1'b0;
    logic rst;
    int n_checks = 0;
    int n_errors = 0;
    mux_sel_scanner_if bus ();
    mux_sel_scanner #(.DWELL(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.i_mux_y = 8'hA0 | {6'd0, bus.o_sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_sample(input string tag, input int gap, input logic [1:0] ch);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.o_valid && n < 50);
        check({tag, "_gap"}, n, gap);
        check({tag, "_ch"}, bus.o_ch, ch);
        check({tag, "_data"}, bus.o_data, 8'hA0 + ch);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_en = 1'b0;
        bus.i_ch_en = 4'b0000;
        bus.i_ready = 1'b0;
        step();
        step();
        check("rst_sel", bus.o_sel, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_ch", bus.o_ch, 0);
        check("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        bus.i_en = 1'b1;
        bus.i_ch_en = 4'b1111;
        bus.i_ready = 1'b1;
        expect_sample("scan0", 5, 0);
        expect_sample("scan1", 5, 1);
        expect_sample("scan2", 5, 2);
        expect_sample("scan3", 5, 3);
        expect_sample("scan4", 5, 0);
        bus.i_ch_en = 4'b1010;
        expect_sample("skip0", 5, 1);
        expect_sample("skip1", 5, 3);
        expect_sample("skip2", 5, 1);
        expect_sample("skip3", 5, 3);
        bus.i_ch_en = 4'b0100;
        expect_sample("single0", 5, 2);
        expect_sample("single1", 5, 2);
        expect_sample("single2", 5, 2);
        bus.i_ch_en = 4'b1111;
        bus.i_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", bus.o_valid, 1);
            check("bp_data", bus.o_data, 8'hA2);
            check("bp_ch", bus.o_ch, 2);
            check("bp_sel", bus.o_sel, 2);
        end
        bus.i_ready = 1'b1;
        step();
        check("bp_adv_sel", bus.o_sel, 3);
        check("bp_adv_valid", bus.o_valid, 0);
        expect_sample("bp_next", 4, 3);
        step();
        check("ab_sel0", bus.o_sel, 0);
        check("ab_busy0", bus.o_busy, 1);
        step();
        bus.i_en = 1'b0;
        step();
        check("ab_busy", bus.o_busy, 0);
        check("ab_valid", bus.o_valid, 0);
        check("ab_sel", bus.o_sel, 0);
        step();
        check("ab_valid2", bus.o_valid, 0);
        bus.i_en = 1'b1;
        expect_sample("ab_restart", 5, 0);
        step();
        check("mc_sel", bus.o_sel, 1);
        bus.i_ch_en = 4'b0001;
        expect_sample("mc_ch1", 4, 1);
        expect_sample("mc_ch0a", 5, 0);
        expect_sample("mc_ch0b", 5, 0);
        bus.i_ch_en = 4'b0000;
        step();
        check("em_busy", bus.o_busy, 0);
        check("em_valid", bus.o_valid, 0);
        check("em_sel", bus.o_sel, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("em_idle_busy", bus.o_busy, 0);
        end
        bus.i_ch_en = 4'b0100;
        step();
        check("mr_sel", bus.o_sel, 2);
        check("mr_busy", bus.o_busy, 1);
        step();
        rst = 1'b1;
        step();
        check("mr_rst_sel", bus.o_sel, 0);
        check("mr_rst_valid", bus.o_valid, 0);
        check("mr_rst_data", bus.o_data, 0);
        check("mr_rst_ch", bus.o_ch, 0);
        check("mr_rst_busy", bus.o_busy, 0);
        step();
        check("mr_rst2_busy", bus.o_busy, 0);
        rst = 1'b0;
        bus.i_en = 1'b0;
        step();
        check("post_busy", bus.o_busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
